// File: rtl/single_to_unsigned_int.sv
// IEEE 754 single to 32-bit unsigned integer converter, three register stages plus output register.
// Define SINGLE_TO_UNSIGNED_INT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise truncates toward zero.
module single_to_unsigned_int (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic        a_valid,
  input  logic        hold,
  output logic [31:0] z,
  output logic        z_valid,
  output logic        z_invalid
);

  logic        s1_valid_q, s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q;
  logic [7:0]  s1_exp_q;
  logic [23:0] s1_sig_q;
  logic        s1_nan_d, s1_inf_d, s1_zero_d;
  logic [23:0] s1_sig_d;

  logic        s2_valid_q, s2_sign_q, s2_nan_q, s2_inf_q, s2_big_q;
  logic [31:0] s2_int_q;
  logic        s2_big_d;
  logic [31:0] s2_int_d;
  logic [5:0]  shamt_s;
`ifdef SINGLE_TO_UNSIGNED_INT_ROUND_NEAREST_EN
  logic        s2_guard_q, s2_sticky_q;
  logic        s2_guard_d, s2_sticky_d;
  logic [55:0] shifted_s;
`endif

  logic        s3_valid_q, s3_sign_q, s3_nan_q, s3_infbig_q, s3_ovf_q;
  logic [31:0] s3_mag_q;
  logic        inc_s;
  logic [32:0] sum_s;

  logic [31:0] z_d;
  logic        z_invalid_d;
  logic [31:0] z_q;
  logic        z_valid_q, z_invalid_q;

  // Stage 1 decode: classify operand and form the significand with hidden bit.
  always_comb begin
    s1_zero_d = (a[30:23] == 8'd0);
    s1_nan_d  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    s1_inf_d  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    s1_sig_d  = {~s1_zero_d, a[22:0]};
  end

  // Stage 2 align: integer part sits at bits [55:24] of sig << (e-126).
  always_comb begin
    s2_big_d = (s1_exp_q >= 8'd159);
    shamt_s  = 6'(s1_exp_q - 8'd126);
`ifdef SINGLE_TO_UNSIGNED_INT_ROUND_NEAREST_EN
    shifted_s = {32'd0, s1_sig_q} << shamt_s;
    if (s1_zero_q || (s1_exp_q < 8'd126)) begin
      s2_int_d    = 32'd0;
      s2_guard_d  = 1'b0;
      s2_sticky_d = (s1_sig_q != 24'd0);
    end else begin
      s2_int_d    = shifted_s[55:24];
      s2_guard_d  = shifted_s[23];
      s2_sticky_d = (shifted_s[22:0] != 23'd0);
    end
`else
    if (s1_zero_q || (s1_exp_q < 8'd126)) begin
      s2_int_d = 32'd0;
    end else begin
      s2_int_d = 32'(({32'd0, s1_sig_q} << shamt_s) >> 24);
    end
`endif
  end

  // Stage 3 round: overflow of the increment is kept for saturation.
  always_comb begin
`ifdef SINGLE_TO_UNSIGNED_INT_ROUND_NEAREST_EN
    inc_s = s2_guard_q & (s2_sticky_q | s2_int_q[0]);
`else
    inc_s = 1'b0;
`endif
    sum_s = {1'b0, s2_int_q} + {32'd0, inc_s};
  end

  // Output resolve in priority order: NaN, positive overflow, negative non-zero, negative zero, rounding overflow.
  always_comb begin
    if (s3_nan_q) begin
      z_d = 32'd0;          z_invalid_d = 1'b1;
    end else if (!s3_sign_q && s3_infbig_q) begin
      z_d = 32'hFFFF_FFFF;  z_invalid_d = 1'b1;
    end else if (s3_sign_q && (s3_infbig_q || s3_ovf_q || (s3_mag_q != 32'd0))) begin
      z_d = 32'd0;          z_invalid_d = 1'b1;
    end else if (s3_sign_q) begin
      z_d = 32'd0;          z_invalid_d = 1'b0;
    end else if (s3_ovf_q) begin
      z_d = 32'hFFFF_FFFF;  z_invalid_d = 1'b1;
    end else begin
      z_d = s3_mag_q;       z_invalid_d = 1'b0;
    end
  end

  // Pipeline registers: reset beats hold, hold freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0; s1_sign_q <= 1'b0; s1_nan_q <= 1'b0; s1_inf_q <= 1'b0;
      s1_zero_q  <= 1'b0; s1_exp_q  <= 8'd0; s1_sig_q <= 24'd0;
      s2_valid_q <= 1'b0; s2_sign_q <= 1'b0; s2_nan_q <= 1'b0; s2_inf_q <= 1'b0;
      s2_big_q   <= 1'b0; s2_int_q  <= 32'd0;
`ifdef SINGLE_TO_UNSIGNED_INT_ROUND_NEAREST_EN
      s2_guard_q <= 1'b0; s2_sticky_q <= 1'b0;
`endif
      s3_valid_q <= 1'b0; s3_sign_q <= 1'b0; s3_nan_q <= 1'b0; s3_infbig_q <= 1'b0;
      s3_ovf_q   <= 1'b0; s3_mag_q  <= 32'd0;
      z_q <= 32'd0; z_valid_q <= 1'b0; z_invalid_q <= 1'b0;
    end else if (hold) begin
      z_q <= z_q; z_valid_q <= z_valid_q; z_invalid_q <= z_invalid_q;
    end else begin
      s1_valid_q <= a_valid;   s1_sign_q <= a[31];    s1_nan_q <= s1_nan_d;
      s1_inf_q   <= s1_inf_d;  s1_zero_q <= s1_zero_d; s1_exp_q <= a[30:23];
      s1_sig_q   <= s1_sig_d;
      s2_valid_q <= s1_valid_q; s2_sign_q <= s1_sign_q; s2_nan_q <= s1_nan_q;
      s2_inf_q   <= s1_inf_q;   s2_big_q  <= s2_big_d;  s2_int_q <= s2_int_d;
`ifdef SINGLE_TO_UNSIGNED_INT_ROUND_NEAREST_EN
      s2_guard_q <= s2_guard_d; s2_sticky_q <= s2_sticky_d;
`endif
      s3_valid_q  <= s2_valid_q; s3_sign_q <= s2_sign_q; s3_nan_q <= s2_nan_q;
      s3_infbig_q <= s2_inf_q | s2_big_q;
      s3_ovf_q    <= sum_s[32];  s3_mag_q  <= sum_s[31:0];
      z_q <= z_d; z_valid_q <= s3_valid_q; z_invalid_q <= z_invalid_d;
    end
  end

  assign z         = z_q;
  assign z_valid   = z_valid_q;
  assign z_invalid = z_invalid_q;

endmodule
